// File: rtl/traffic_cmd_master.sv
// traffic_cmd_master
//   Expands high-level requests (LOAD / ENABLE / DISABLE / NOTRANSITION) taken over a
//   valid/ready handshake into timed, single-cycle commands for the traffic_lights
//   command port. Commands are spaced CMD_GAP idle cycles apart.
//
// Parameters
//   CMD_GAP  idle cycles after every issued command (0..15)
//   DATA_W   width of the timing fields and cmd_data_o
//
// Ports
//   clk_i            clock
//   srst_n_i         synchronous active-low reset
//   req_valid_i      request valid
//   req_ready_o      request ready, high only while idle
//   req_op_i         0=LOAD 1=ENABLE 2=DISABLE 3=NOTRANSITION
//   req_red_ms_i     red time (LOAD only)
//   req_yellow_ms_i  yellow time (LOAD only)
//   req_green_ms_i   green time (LOAD only)
//   cmd_type_o       0=ENABLE 1=DISABLE 2=NOTRANSITION 3=SET_GREEN 4=SET_RED 5=SET_YELLOW
//   cmd_valid_o      one-cycle command strobe
//   cmd_data_o       command payload (ms value for SET_*, 0 otherwise)
//   done_o           pulse coincident with the last command of a request
module traffic_cmd_master #(
  parameter int CMD_GAP = 1,
  parameter int DATA_W  = 16
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [DATA_W-1:0] req_red_ms_i,
  input  logic [DATA_W-1:0] req_yellow_ms_i,
  input  logic [DATA_W-1:0] req_green_ms_i,
  output logic [2:0]        cmd_type_o,
  output logic              cmd_valid_o,
  output logic [DATA_W-1:0] cmd_data_o,
  output logic              done_o
);

  localparam logic [1:0] OP_LOAD    = 2'd0;
  localparam logic [1:0] OP_ENABLE  = 2'd1;
  localparam logic [1:0] OP_DISABLE = 2'd2;

  localparam logic [2:0] CT_ENABLE  = 3'd0;
  localparam logic [2:0] CT_DISABLE = 3'd1;
  localparam logic [2:0] CT_NOTRANS = 3'd2;
  localparam logic [2:0] CT_GREEN   = 3'd3;
  localparam logic [2:0] CT_RED     = 3'd4;
  localparam logic [2:0] CT_YELLOW  = 3'd5;

  localparam logic [3:0] GAP_LD = 4'(CMD_GAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state_q;
  logic [3:0]        gap_cnt_q;
  logic [2:0]        idx_q;      // index of the next command to issue
  logic              last_q;     // most recently issued command ends the request
  logic [1:0]        op_q;
  logic [DATA_W-1:0] red_q;
  logic [DATA_W-1:0] yel_q;
  logic [DATA_W-1:0] grn_q;

  // A time of 0 would stall the light controller, so it is sent as 1.
  function automatic logic [DATA_W-1:0] clamp_zero(input logic [DATA_W-1:0] v);
    return (v == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : v;
  endfunction

  logic              accept;
  logic              advance_pt;
  logic              issue_now;
  logic              finish_now;
  logic [1:0]        sel_op;
  logic [2:0]        sel_idx;
  logic [DATA_W-1:0] sel_red;
  logic [DATA_W-1:0] sel_yel;
  logic [DATA_W-1:0] sel_grn;
  logic [2:0]        nxt_type;
  logic [DATA_W-1:0] nxt_data;
  logic              nxt_last;

  // Command selection: on the accepting edge the first command comes straight from
  // the request inputs, afterwards from the captured copies.
  always_comb begin
    accept     = (state_q == IDLE) && req_ready_o && req_valid_i;
    advance_pt = ((state_q == ISSUE) && (CMD_GAP == 0)) ||
                 ((state_q == GAP) && (gap_cnt_q == 4'd0));
    issue_now  = accept || (advance_pt && !last_q);
    finish_now = advance_pt && last_q;

    sel_op  = accept ? req_op_i : op_q;
    sel_idx = accept ? 3'd0 : idx_q;
    sel_red = accept ? clamp_zero(req_red_ms_i)    : red_q;
    sel_yel = accept ? clamp_zero(req_yellow_ms_i) : yel_q;
    sel_grn = accept ? clamp_zero(req_green_ms_i)  : grn_q;

    nxt_type = CT_NOTRANS;
    nxt_data = '0;
    nxt_last = 1'b1;
    case (sel_op)
      OP_LOAD: begin
        nxt_last = 1'b0;
        case (sel_idx)
          3'd0:    nxt_type = CT_NOTRANS;
          3'd1:    begin nxt_type = CT_RED;    nxt_data = sel_red; end
          3'd2:    begin nxt_type = CT_YELLOW; nxt_data = sel_yel; end
          3'd3:    begin nxt_type = CT_GREEN;  nxt_data = sel_grn; end
          default: begin nxt_type = CT_ENABLE; nxt_last = 1'b1;    end
        endcase
      end
      OP_ENABLE:  nxt_type = CT_ENABLE;
      OP_DISABLE: nxt_type = CT_DISABLE;
      default:    nxt_type = CT_NOTRANS;
    endcase
  end

  // Request capture: data path, not reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q  <= req_op_i;
      red_q <= clamp_zero(req_red_ms_i);
      yel_q <= clamp_zero(req_yellow_ms_i);
      grn_q <= clamp_zero(req_green_ms_i);
    end
  end

  // Sequencer and registered command outputs.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q     <= IDLE;
      req_ready_o <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= 3'd0;
      cmd_data_o  <= '0;
      done_o      <= 1'b0;
      gap_cnt_q   <= 4'd0;
      idx_q       <= 3'd0;
      last_q      <= 1'b0;
    end else begin
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= 3'd0;
      cmd_data_o  <= '0;
      done_o      <= 1'b0;

      if (issue_now) begin
        state_q     <= ISSUE;
        req_ready_o <= 1'b0;
        cmd_valid_o <= 1'b1;
        cmd_type_o  <= nxt_type;
        cmd_data_o  <= nxt_data;
        done_o      <= nxt_last;
        last_q      <= nxt_last;
        idx_q       <= sel_idx + 3'd1;
        gap_cnt_q   <= GAP_LD;
      end else if (finish_now) begin
        state_q     <= IDLE;
        req_ready_o <= 1'b1;
      end else begin
        case (state_q)
          IDLE:  req_ready_o <= 1'b1;
          ISSUE: begin
            // Only reached with CMD_GAP >= 1, so the counter never wraps.
            state_q   <= GAP;
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
          GAP:     gap_cnt_q <= gap_cnt_q - 4'd1;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_traffic_cmd_master.sv
module tb_traffic_cmd_master;

  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_valid0;
  logic [1:0]    req_op;
  logic [DW-1:0] req_red, req_yel, req_grn;

  logic          ready, valid, done;
  logic [2:0]    ctype;
  logic [DW-1:0] cdata;
  logic          ready0, valid0, done0;
  logic [2:0]    ctype0;
  logic [DW-1:0] cdata0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0]    t;
    logic [DW-1:0] d;
    logic          dn;
    int            cy;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];

  traffic_cmd_master #(.CMD_GAP(1), .DATA_W(DW)) dut (
    .clk_i(clk), .srst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(ready),
    .req_op_i(req_op), .req_red_ms_i(req_red), .req_yellow_ms_i(req_yel),
    .req_green_ms_i(req_grn), .cmd_type_o(ctype), .cmd_valid_o(valid),
    .cmd_data_o(cdata), .done_o(done)
  );

  traffic_cmd_master #(.CMD_GAP(0), .DATA_W(DW)) dut0 (
    .clk_i(clk), .srst_n_i(rst_n), .req_valid_i(req_valid0), .req_ready_o(ready0),
    .req_op_i(req_op), .req_red_ms_i(req_red), .req_yellow_ms_i(req_yel),
    .req_green_ms_i(req_grn), .cmd_type_o(ctype0), .cmd_valid_o(valid0),
    .cmd_data_o(cdata0), .done_o(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] cl(input logic [DW-1:0] v);
    return (v == 0) ? 16'd1 : v;
  endfunction

  function automatic exp_t mk(input logic [2:0] t, input logic [DW-1:0] d,
                              input logic dn, input int cy);
    exp_t e;
    e.t = t; e.d = d; e.dn = dn; e.cy = cy;
    return e;
  endfunction

  // Scoreboard monitor for the CMD_GAP=1 instance.
  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got type=%0d data=%0d at cyc=%0d, none expected",
                 ctype, cdata, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (ctype !== e.t || cdata !== e.d || done !== e.dn || cyc != e.cy) begin
          errors++;
          $display("FAIL cmd: got type=%0d data=%0d done=%0d cyc=%0d, want type=%0d data=%0d done=%0d cyc=%0d",
                   ctype, cdata, done, cyc, e.t, e.d, e.dn, e.cy);
        end
      end
    end else begin
      checks++;
      if (ctype !== 3'd0 || cdata !== '0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs: got type=%0d data=%0d done=%0d at cyc=%0d, want 0/0/0",
                 ctype, cdata, done, cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_req(input logic [1:0] op, input logic [DW-1:0] r,
                          input logic [DW-1:0] y, input logic [DW-1:0] g,
                          output int t_acc);
    int gs;
    gs = 2;
    req_op = op; req_red = r; req_yel = y; req_grn = g;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (ready) break;
      @(negedge clk);
    end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL accept_timeout: got ready=%0d, want 1 within 100 cycles", ready);
      req_valid = 1'b0;
      t_acc = -1;
      return;
    end
    t_acc = cyc + 1;
    if (op == 2'd0) begin
      q.push_back(mk(3'd2, 16'd0,  1'b0, t_acc));
      q.push_back(mk(3'd4, cl(r),  1'b0, t_acc + gs));
      q.push_back(mk(3'd5, cl(y),  1'b0, t_acc + 2 * gs));
      q.push_back(mk(3'd3, cl(g),  1'b0, t_acc + 3 * gs));
      q.push_back(mk(3'd0, 16'd0,  1'b1, t_acc + 4 * gs));
    end else begin
      q.push_back(mk((op == 2'd1) ? 3'd0 : (op == 2'd2) ? 3'd1 : 3'd2, 16'd0, 1'b1, t_acc));
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending commands, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || ctype !== 3'd0 || cdata !== '0 || done !== 1'b0 || ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%0d type=%0d data=%0d done=%0d ready=%0d, want all 0",
                 valid, ctype, cdata, done, ready);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || ready0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got ready=%0d ready0=%0d, want 1/1", ready, ready0);
    end
  endtask

  task automatic test_load_basic();
    int t;
    send_req(2'd0, 16'd2000, 16'd1000, 16'd2000, t);
    repeat (t + 9 - cyc) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready_busy: got ready=%0d at +9, want 0", ready);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_back: got ready=%0d at +10, want 1", ready);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL load_complete: got %0d pending at +10, want 0", q.size());
    end
    wait_drain();
  endtask

  task automatic test_clamp();
    int t;
    send_req(2'd0, 16'd0, 16'd65535, 16'd10, t);
    wait_drain();
  endtask

  task automatic test_single_ops();
    int t;
    send_req(2'd1, 16'd7, 16'd7, 16'd7, t);
    wait_drain();
    send_req(2'd3, 16'd0, 16'd0, 16'd0, t);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    send_req(2'd0, 16'd100, 16'd200, 16'd300, t1);
    send_req(2'd2, 16'd0, 16'd0, 16'd0, t2);
    checks++;
    if (t2 != t1 + 11) begin
      errors++;
      $display("FAIL b2b_accept: got accept edge %0d, want %0d", t2, t1 + 11);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int t;
    send_req(2'd0, 16'd500, 16'd600, 16'd700, t);
    repeat (t + 4 - cyc) @(negedge clk);
    rst_n = 1'b0;
    // SET_GREEN and ENABLE must never appear.
    void'(q.pop_back());
    void'(q.pop_back());
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_hold: got ready=%0d valid=%0d, want 0/0", ready, valid);
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    send_req(2'd1, 16'd0, 16'd0, 16'd0, t);
    wait_drain();
  endtask

  task automatic test_gap0();
    exp_t e;
    req_op = 2'd0; req_red = 16'd7; req_yel = 16'd0; req_grn = 16'd9;
    req_valid0 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (ready0) break;
      @(negedge clk);
    end
    q0.push_back(mk(3'd2, 16'd0, 1'b0, 1));
    q0.push_back(mk(3'd4, 16'd7, 1'b0, 2));
    q0.push_back(mk(3'd5, 16'd1, 1'b0, 3));
    q0.push_back(mk(3'd3, 16'd9, 1'b0, 4));
    q0.push_back(mk(3'd0, 16'd0, 1'b1, 5));
    @(negedge clk);
    req_valid0 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      e = q0.pop_front();
      checks++;
      if (valid0 !== 1'b1 || ctype0 !== e.t || cdata0 !== e.d || done0 !== e.dn) begin
        errors++;
        $display("FAIL gap0_cmd%0d: got valid=%0d type=%0d data=%0d done=%0d, want 1/%0d/%0d/%0d",
                 e.cy, valid0, ctype0, cdata0, done0, e.t, e.d, e.dn);
      end
      checks++;
      if (ready0 !== 1'b0) begin
        errors++;
        $display("FAIL gap0_busy%0d: got ready=%0d, want 0", k, ready0);
      end
      @(negedge clk);
    end
    checks++;
    if (ready0 !== 1'b1 || valid0 !== 1'b0) begin
      errors++;
      $display("FAIL gap0_ready6: got ready=%0d valid=%0d, want 1/0", ready0, valid0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_valid0 = 1'b0;
    req_op = 2'd0; req_red = '0; req_yel = '0; req_grn = '0;
    @(negedge clk);
    test_reset();
    test_load_basic();
    test_clamp();
    test_single_ops();
    test_back_to_back();
    test_reset_mid();
    test_gap0();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
